// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions for the LSU memory master.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;

  // High for misaligned accesses and for funct3 codes the access type does not support
  function automatic logic lsu_misaligned(input logic we, input logic [2:0] f3,
                                          input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lo[0];
      F3_W:    bad = (lo != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core request/response and data-memory signals of the LSU memory master.
interface lsu_mem_master_if #(
  parameter int unsigned MEM_AW = 6,
  parameter int unsigned XLEN   = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction with sign/zero extension, and store-lane merge into a word.
module lsu_lane_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wword
);

  logic [4:0]      bsh;
  logic [4:0]      hsh;
  logic [7:0]      b;
  logic [15:0]     h;
  logic [XLEN-1:0] bmask;
  logic [XLEN-1:0] hmask;

  always_comb begin
    bsh   = {addr_lo, 3'b000};
    hsh   = {addr_lo[1], 4'b0000};
    b     = 8'(word >> bsh);
    h     = 16'(word >> hsh);
    bmask = XLEN'(8'hFF) << bsh;
    hmask = XLEN'(16'hFFFF) << hsh;

    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{(XLEN-8){b[7]}}, b};
      F3_H:    rdata = {{(XLEN-16){h[15]}}, h};
      F3_W:    rdata = word;
      F3_BU:   rdata = XLEN'(b);
      F3_HU:   rdata = XLEN'(h);
      default: rdata = '0;
    endcase

    wword = wdata;
    case (funct3)
      F3_B:    wword = (word & ~bmask) | (XLEN'(wdata[7:0]) << bsh);
      F3_H:    wword = (word & ~hmask) | (XLEN'(wdata[15:0]) << hsh);
      default: wword = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator: one request in flight, RMW for sub-word stores,
// misalignment reported without touching memory.
module lsu_mem_master
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_AW = 6,
  parameter int unsigned XLEN   = 32
) (
  input logic              clk,
  input logic              rst,
  lsu_mem_master_if.master bus
);

  localparam int unsigned AW = MEM_AW + 2;

  lsu_state_t      state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] st_word;
  logic            req_bad;
  logic            unused_addr_hi;

  assign req_bad        = lsu_misaligned(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
  assign unused_addr_hi = ^bus.req_addr[XLEN-1:AW];

  // word_q carries store data until RD replaces it with the merged word
  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .word    (bus.mem_rdata),
    .wdata   (word_q),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .rdata   (ld_data),
    .wword   (st_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr[AW-1:0];
            word_q  <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= req_bad;
            if (req_bad)                                state <= RESP;
            else if (bus.req_we && bus.req_funct3 == F3_W) state <= WR;
            else                                        state <= RD;
          end
        end
        RD: begin
          if (we_q) begin
            word_q <= st_word;
            state  <= WR;
          end else begin
            rdata_q <= ld_data;
            state   <= RESP;
          end
        end
        WR:      state <= RESP;
        RESP:    if (bus.resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and handshakes drop in the same cycle reset is asserted
  assign bus.req_ready  = rst & (state == IDLE);
  assign bus.mem_read   = rst & (state == RD);
  assign bus.mem_write  = rst & (state == WR);
  assign bus.resp_valid = rst & (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = addr_q[AW-1:2];
  assign bus.mem_wdata  = word_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed and random load/store traffic against a byte-array reference model.
module tb_lsu_mem_master;
  import riscv_pkg::*;

  localparam int unsigned MEM_AW = 6;
  localparam int unsigned XLEN   = 32;

  logic clk = 1'b0;
  logic rst;

  lsu_mem_master_if #(.MEM_AW(MEM_AW), .XLEN(XLEN)) bus ();

  lsu_mem_master #(.MEM_AW(MEM_AW), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, posedge write; preload port for setup
  logic [31:0] mem [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_write)  mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pl_en)     mem[pl_idx]       <= pl_val;
  end

  logic [7:0] ref_bytes [256];
  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [5:0] strobe_addr = 6'd0;

  always @(posedge clk) begin
    if (bus.mem_read)  rd_cnt++;
    if (bus.mem_write) wr_cnt++;
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if (bus.mem_read || bus.mem_write) strobe_addr = bus.mem_addr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = 6'(idx);
    pl_val = val;
    @(posedge clk); #1;
    pl_en  = 1'b0;
    for (int i = 0; i < 4; i++) ref_bytes[4*idx+i] = val[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // Reference: little-endian byte array, access size from funct3, 256-byte wrap
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int lat, output int nrd, output int nwr);
    int  a, size;
    logic ok;
    a    = int'(addr[7:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok   = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    err  = !ok || (a % size != 0);
    rd = 32'd0; lat = 1; nrd = 0; nwr = 0;
    if (err) return;
    if (!we) begin
      for (int i = 0; i < size; i++) rd = rd | (32'(ref_bytes[a+i]) << (8*i));
      if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
      lat = 2; nrd = 1;
    end else begin
      for (int i = 0; i < size; i++) ref_bytes[a+i] = wd[8*i +: 8];
      lat = (size == 4) ? 2 : 3;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end
  endtask

  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input int stall,
                         output logic [31:0] obs_rd, output logic obs_err);
    logic [31:0] e_rd;
    logic        e_err, accepted;
    int          e_lat, e_nrd, e_nwr, rd0, wr0, lat;
    model(we, f3, addr, wd, e_rd, e_err, e_lat, e_nrd, e_nwr);
    rd0 = rd_cnt; wr0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) begin
      accepted = bus.req_ready;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    obs_rd = 32'd0; obs_err = 1'b0;
    check($sformatf("%s accept", tag), 32'(accepted), 32'd1);
    if (!accepted) return;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    obs_rd  = bus.resp_rdata;
    obs_err = bus.resp_err;
    check($sformatf("%s latency", tag), 32'(lat), 32'(e_lat));
    check($sformatf("%s rdata", tag), obs_rd, e_rd);
    check($sformatf("%s err", tag), 32'(obs_err), 32'(e_err));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s stall valid", tag), 32'(bus.resp_valid), 32'd1);
      check($sformatf("%s stall rdata", tag), bus.resp_rdata, e_rd);
      check($sformatf("%s stall req_ready", tag), 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check($sformatf("%s valid drop", tag), 32'(bus.resp_valid), 32'd0);
    check($sformatf("%s ready back", tag), 32'(bus.req_ready), 32'd1);
    check($sformatf("%s read strobes", tag), 32'(rd_cnt - rd0), 32'(e_nrd));
    check($sformatf("%s write strobes", tag), 32'(wr_cnt - wr0), 32'(e_nwr));
    if (e_nrd + e_nwr > 0)
      check($sformatf("%s mem_addr", tag), 32'(strobe_addr), 32'(addr[7:2]));
  endtask

  initial begin
    logic [31:0] r, old;
    logic        e;
    rst = 1'b0;
    pl_en = 1'b0; pl_idx = 6'd0; pl_val = 32'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;

    // Reset: memory filled while the block is held in reset
    for (int w = 0; w < 64; w++) preload(w, $urandom);
    check("rst req_ready", 32'(bus.req_ready), 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    rst = 1'b1; #1;
    check("post rst req_ready", 32'(bus.req_ready), 32'd1);
    check("post rst rdata", bus.resp_rdata, 32'd0);
    check("post rst err", 32'(bus.resp_err), 32'd0);
    check("post rst writes", 32'(wr_cnt), 32'd0);

    // Byte loads, sign and zero extension
    preload(1, 32'h8000_00F0);
    run_txn("t1 lb", 1'b0, F3_B, 32'h4, 32'h0, 0, r, e);
    check("t1 lb const", r, 32'hFFFF_FFF0);
    run_txn("t1 lbu", 1'b0, F3_BU, 32'h4, 32'h0, 0, r, e);
    check("t1 lbu const", r, 32'h0000_00F0);

    // Byte store read-modify-write then word load
    preload(4, 32'h1122_3344);
    run_txn("t2 sb", 1'b1, F3_B, 32'h12, 32'h0000_00AB, 0, r, e);
    check("t2 mem4", mem[4], 32'h11AB_3344);
    run_txn("t2 lw", 1'b0, F3_W, 32'h10, 32'h0, 0, r, e);
    check("t2 lw const", r, 32'h11AB_3344);

    // Misaligned word store
    old = mem[1];
    run_txn("t3 sw", 1'b1, F3_W, 32'h6, 32'hDEAD_BEEF, 0, r, e);
    check("t3 err const", 32'(e), 32'd1);
    check("t3 mem1", mem[1], old);

    // Half load with response back-pressure
    preload(1, 32'h9234_0000);
    run_txn("t4 lh", 1'b0, F3_H, 32'h6, 32'h0, 3, r, e);
    check("t4 lh const", r, 32'hFFFF_9234);

    // Reset during the write cycle of a word store
    old = mem[2];
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h8; bus.req_wdata = 32'd5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("t5 in WR", 32'(bus.mem_write), 32'd1);
    rst = 1'b0; #1;
    check("t5 write forced low", 32'(bus.mem_write), 32'd0);
    check("t5 req_ready low", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    check("t5 mem2", mem[2], old);
    check("t5 resp_valid", 32'(bus.resp_valid), 32'd0);
    rst = 1'b1; #1;
    check("t5 idle", 32'(bus.req_ready), 32'd1);
    check("t5 resp_valid after", 32'(bus.resp_valid), 32'd0);
    run_txn("t5 lw", 1'b0, F3_W, 32'h8, 32'h0, 0, r, e);

    // Back-to-back and address wrap
    run_txn("t6 sw", 1'b1, F3_W, 32'h0, 32'd7, 0, r, e);
    run_txn("t6 lw", 1'b0, F3_W, 32'h0, 32'h0, 0, r, e);
    check("t6 lw const", r, 32'd7);
    run_txn("t6 wrap", 1'b0, F3_W, 32'h100, 32'h0, 0, r, e);
    check("t6 wrap const", r, 32'd7);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      run_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom, $urandom, int'($urandom_range(0, 2)), r, e);
    end

    check("both strobes", 32'(both_cnt), 32'd0);
    for (int w = 0; w < 64; w++) check($sformatf("final mem%0d", w), mem[w], ref_word(w));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
